score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//   Air-hockey score controller. Counts goals for two players in BCD and
//   drives the 4-digit multiplexed display: hex3:hex2 = P1 tens:units,
//   hex1:hex0 = P2 tens:units. Decimal points flag events: they blink after
//   a goal and stay lit for the winner. Sits between the puck/goal logic and
//   the 7-segment display mux.
// PARAMETERS
//   WIN_SCORE   11          score that ends the game (1..99)
//   HOLD_CYCLES 50_000_000  post-goal hold time in clk cycles (>=2)
//   BLINK_W     24          free-running blink counter width; blink = MSB
// PORTS
//   clk       in   1  system clock
//   reset     in   1  asynchronous, active-low reset
//   goal_p1   in   1  1-cycle pulse: P1 scored
//   goal_p2   in   1  1-cycle pulse: P2 scored
//   game_rst  in   1  1-cycle pulse: synchronous new-game request
//   hex3      out  4  P1 tens digit, BCD
//   hex2      out  4  P1 units digit, BCD
//   hex1      out  4  P2 tens digit, BCD
//   hex0      out  4  P2 units digit, BCD
//   dp_out    out  4  decimal points, active-low (1 = off); bit i -> digit i
//   busy      out  1  1 while in HOLD; goals are ignored
//   game_over out  1  1 while in OVER
//   winner    out  1  valid when game_over: 0 = P1, 1 = P2
// BEHAVIOUR
//   Outputs are registered. reset low: all hex = 0, dp_out = 4'b1111,
//   busy = game_over = winner = 0, state PLAY, timers = 0.
//   FSM states: PLAY, HOLD, OVER.
//   PLAY:
//     - Exactly one goal pulse -> that player's score += 1 in BCD.
//       Units 9 -> 0 with tens += 1; tens never exceeds 9.
//     - Digits update 1 cycle after the pulse.
//     - If the new score == WIN_SCORE -> OVER, winner = scorer.
//     - Otherwise -> HOLD, with hold timer loaded to HOLD_CYCLES-1 and the
//       scorer stored.
//     - goal_p1 and goal_p2 in the same cycle: both ignored, no change.
//   HOLD:
//     - busy = 1. Timer decrements every cycle; at 0 -> PLAY.
//     - Time in HOLD is exactly HOLD_CYCLES cycles.
//     - Goal pulses are dropped.
//     - Scorer's dp pair = {2{blink}}: P1 -> dp_out[3:2], P2 -> dp_out[1:0].
//       The other pair stays 2'b11.
//   OVER:
//     - game_over = 1. Winner's dp pair = 2'b00 (steady lit), other pair 11.
//     - Goals are dropped. Only game_rst or reset leaves this state.
//   game_rst (any state, highest priority over goals in the same cycle):
//     next cycle scores = 0, state PLAY, busy = game_over = winner = 0,
//     dp_out = 4'b1111.
//   Blink counter: free-running, cleared only by reset, wraps modulo
//     2^BLINK_W. It is not affected by game_rst.
//   Reset asserted mid-HOLD/OVER: immediate (asynchronous) return to reset
//     values. The count restarts from reset-release.
// TESTING (bench params: WIN_SCORE=11, HOLD_CYCLES=4, BLINK_W=2)
//   1. Release reset; one goal_p1 pulse -> next cycle hex3:hex2 = 0:1,
//      busy = 1 for exactly 4 cycles, dp_out[3:2] toggles every 2 cycles,
//      dp_out[1:0] = 11.
//   2. goal_p2 during HOLD -> ignored; hex1:hex0 remains 0:0.
//   3. goal_p1 and goal_p2 in the same PLAY cycle -> no score change,
//      busy stays 0.
//   4. Ten P2 goals, each spaced past HOLD -> hex1:hex0 = 1:0
//      (BCD carry from 0:9).
//   5. Eleventh P2 goal -> hex1:hex0 = 1:1, game_over = 1, winner = 1,
//      dp_out = 4'b1100 steady. Further goals are ignored.
//   6. game_rst in the same cycle as goal_p1 while in OVER -> next cycle
//      all hex = 0, dp_out = 1111, game_over = 0. Async reset pulse
//      mid-HOLD -> outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Air-hockey score controller: BCD goal counters for two players, post-goal hold
// with blinking decimal points, and a steady winner indication on the 4-digit display.
module score_display_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_W     = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       game_rst,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic       busy,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] dbg_state
);

    localparam int         TW      = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HOLD = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t             state_q;
    logic [7:0]         p1_q, p2_q;
    logic [TW-1:0]      hold_q;
    logic               scorer_q;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [3:0]         dp_q;
    logic               busy_q, game_over_q, winner_q;
    logic [7:0]         p1_inc, p2_inc, new_score;
    logic               blink;

    // Units wrap 9 -> 0 with a tens carry; tens saturates at 9.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd9 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    assign p1_inc    = bcd_inc(p1_q);
    assign p2_inc    = bcd_inc(p2_q);
    assign new_score = goal_p2 ? p2_inc : p1_inc;
    assign blink_d   = blink_q + BLINK_W'(1);
    assign blink     = blink_d[BLINK_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_PLAY;
            p1_q        <= 8'h00;
            p2_q        <= 8'h00;
            hold_q      <= '0;
            scorer_q    <= 1'b0;
            dp_q        <= 4'b1111;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else if (game_rst) begin
            state_q     <= S_PLAY;
            p1_q        <= 8'h00;
            p2_q        <= 8'h00;
            hold_q      <= '0;
            scorer_q    <= 1'b0;
            dp_q        <= 4'b1111;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (goal_p1 ^ goal_p2) begin
                        if (goal_p2) p2_q <= p2_inc;
                        else         p1_q <= p1_inc;
                        if (new_score == WIN_BCD) begin
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                            winner_q    <= goal_p2;
                            busy_q      <= 1'b0;
                            dp_q        <= goal_p2 ? 4'b1100 : 4'b0011;
                        end else begin
                            state_q  <= S_HOLD;
                            hold_q   <= TW'(HOLD_CYCLES - 1);
                            scorer_q <= goal_p2;
                            busy_q   <= 1'b1;
                            dp_q     <= goal_p2 ? {2'b11, blink, blink} : {blink, blink, 2'b11};
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        state_q <= S_PLAY;
                        busy_q  <= 1'b0;
                        dp_q    <= 4'b1111;
                    end else begin
                        hold_q <= hold_q - TW'(1);
                        dp_q   <= scorer_q ? {2'b11, blink, blink} : {blink, blink, 2'b11};
                    end
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    state_q <= S_PLAY;
                    busy_q  <= 1'b0;
                    dp_q    <= 4'b1111;
                end
            endcase
        end
    end

    assign hex3      = p1_q[7:4];
    assign hex2      = p1_q[3:0];
    assign hex1      = p2_q[7:4];
    assign hex0      = p2_q[3:0];
    assign dp_out    = dp_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomised scoreboard bench for score_display_ctrl: a score/hold/over model
// predicts every cycle's outputs, a monitor pops and compares them.
module tb_score_display_ctrl;

    localparam int WIN  = 11;
    localparam int HOLD = 4;
    localparam int BW   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic       game_rst = 1'b0;
    logic [3:0] hex3, hex2, hex1, hex0, dp_out;
    logic       busy, game_over, winner;
    logic [1:0] dbg_state;

    score_display_ctrl #(
        .WIN_SCORE  (WIN),
        .HOLD_CYCLES(HOLD),
        .BLINK_W    (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .goal_p1  (goal_p1),
        .goal_p2  (goal_p2),
        .game_rst (game_rst),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .dp_out   (dp_out),
        .busy     (busy),
        .game_over(game_over),
        .winner   (winner),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [22:0] exp_q[$];

    // Reference model: binary scores, cycles left in hold, game-over flag.
    int m_p1, m_p2, m_hold, m_edges;
    bit m_over, m_win, m_scorer;

    function automatic logic [22:0] act_vec();
        return {hex3, hex2, hex1, hex0, dp_out, busy, game_over, winner};
    endfunction

    function automatic logic [22:0] model_out();
        logic [3:0] dp;
        logic       b;
        b = (((m_edges % (1 << BW)) / (1 << (BW - 1))) != 0);
        if (m_over)        dp = m_win ? 4'b1100 : 4'b0011;
        else if (m_hold > 0) dp = m_scorer ? {2'b11, b, b} : {b, b, 2'b11};
        else               dp = 4'b1111;
        return {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10), dp,
                (m_hold > 0), m_over, (m_over && m_win)};
    endfunction

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_hold = 0; m_edges = 0;
        m_over = 0; m_win = 0; m_scorer = 0;
    endtask

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic drive_step(input bit g1, input bit g2, input bit gr);
        goal_p1  = g1;
        goal_p2  = g2;
        game_rst = gr;
        m_edges++;
        if (gr) begin
            m_p1 = 0; m_p2 = 0; m_hold = 0; m_over = 0; m_win = 0;
        end else if (m_over) begin
            // goals ignored until a new game
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (g1 != g2) begin
            if (g1) m_p1++;
            else    m_p2++;
            if ((g1 ? m_p1 : m_p2) == WIN) begin
                m_over = 1;
                m_win  = g2;
            end else begin
                m_hold   = HOLD;
                m_scorer = g2;
            end
        end
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input bit g1, input bit g2, input bit gr);
        @(posedge clk);
        #1;
        drive_step(g1, g2, gr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", act_vec(), {16'h0000, 4'b1111, 3'b000});
        #1;
        reset = 1'b1;
        model_reset();
        drive_step(0, 0, 0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) check("cycle", act_vec(), exp_q.pop_front());
        end
    end

    initial begin : stimulus
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", act_vec(), {16'h0000, 4'b1111, 3'b000});
        reset = 1'b1;

        drive_step(1, 0, 0);                    // P1 goal, watch the hold and blink
        idle(6);
        cyc(1, 0, 0);
        idle(1);
        cyc(0, 1, 0);                           // dropped during hold
        idle(5);
        cyc(1, 1, 0);                           // simultaneous goals ignored
        idle(2);
        for (int i = 0; i < 11; i++) begin      // P2 wins through the 0:9 -> 1:0 carry
            cyc(0, 1, 0);
            idle(5);
        end
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(3);
        cyc(1, 0, 1);                           // new game beats a goal in OVER
        idle(2);

        cyc(0, 1, 0);
        idle(1);
        async_reset_pulse();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
            if ($urandom_range(0, 149) == 0) async_reset_pulse();
        end
        idle(2);

        repeat (3) @(posedge clk);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
